ps2_mouse_regs: RTL and testbench

PS/2 mouse receiver and register bank feeding the display-side packet reader. Deserializes 11-bit PS/2 frames from the mouse, assembles 3-byte movement packets, and integrates the signed deltas into clamped absolute 8-bit cursor coordinates. The finished status/X/Y registers are exposed through a 2-bit address / 8-bit data read port, with a one-cycle `dav` strobe per completed packet.

---
 rtl/ps2_pkg.sv | 36 +++
 rtl/ps2_mouse_regs_if.sv | 18 +
 rtl/ps2_rx_byte.sv | 73 +++++++
 rtl/ps2_mouse_regs.sv | 110 +++++++++++
 tb/tb_ps2_mouse_regs.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ps2_pkg.sv
// Shared constants and helpers for the PS/2 mouse receiver and register bank.
package ps2_pkg;

  localparam logic [1:0] ADDR_STATUS = 2'd0;
  localparam logic [1:0] ADDR_X      = 2'd1;
  localparam logic [1:0] ADDR_Y      = 2'd2;

  localparam int FRAME_BITS = 11;

  localparam int BTN_L   = 0;
  localparam int BTN_R   = 1;
  localparam int BTN_M   = 2;
  localparam int ALWAYS1 = 3;
  localparam int XSIGN   = 4;
  localparam int YSIGN   = 5;
  localparam int XOVF    = 6;
  localparam int YOVF    = 7;

  typedef enum logic [1:0] {
    BYTE0 = 2'd0,
    BYTE1 = 2'd1,
    BYTE2 = 2'd2
  } pkt_state_e;

  // Saturate a 10-bit signed coordinate candidate into [0, max].
  function automatic logic [7:0] clamp_coord(input logic signed [9:0] v,
                                             input logic [7:0] max);
    if (v < 10'sd0)
      return 8'd0;
    else if (v > $signed({2'b00, max}))
      return max;
    else
      return v[7:0];
  endfunction

endpackage

// File: rtl/ps2_mouse_regs_if.sv
// Pad-side PS/2 lines plus the display-side read port of the mouse register bank.
interface ps2_mouse_regs_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic [1:0] addr;
  logic [7:0] data;
  logic       dav;

  modport slave (
    input  ps2_clk, ps2_data, addr,
    output data, dav
  );

  modport master (
    output ps2_clk, ps2_data, addr,
    input  data, dav
  );
endinterface

// File: rtl/ps2_rx_byte.sv
// PS/2 frame receiver: synchronizers, falling-edge detect, 11-bit deserializer, timeout.
// Define PS2_MOUSE_RX_PARITY_CHECK_EN to drop frames whose odd parity fails.
module ps2_rx_byte
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYC = 5000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       byte_valid,
  output logic       frame_err,
  output logic       timeout,
  output logic [7:0] byte_data
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic [2:0]    clk_sync;   // [1:0] synchronizer, [2] previous synced level
  logic [1:0]    data_sync;
  logic [9:0]    shift;
  logic [3:0]    bit_cnt;
  logic [CW-1:0] idle_cnt;

  logic fall, last_bit, start_ok, stop_ok, parity_good, parity_ok, frame_ok;

  assign fall        = clk_sync[2] & ~clk_sync[1];
  assign last_bit    = fall && (bit_cnt == 4'(FRAME_BITS - 1));
  // After ten shifts: [0] start, [8:1] data, [9] parity; the stop bit is the live sample.
  assign start_ok    = ~shift[0];
  assign stop_ok     = data_sync[1];
  assign parity_good = ^shift[9:1];

`ifdef PS2_MOUSE_RX_PARITY_CHECK_EN
  assign parity_ok = parity_good;
`else
  assign parity_ok = parity_good | 1'b1;
`endif

  assign frame_ok   = start_ok & stop_ok & parity_ok;
  assign byte_valid = last_bit & frame_ok;
  assign frame_err  = last_bit & ~frame_ok;
  assign byte_data  = shift[8:1];
  assign timeout    = clk_sync[1] && (idle_cnt == CW'(TIMEOUT_CYC - 1));

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync  <= 3'b111;
      data_sync <= 2'b11;
      shift     <= '0;
      bit_cnt   <= '0;
      idle_cnt  <= '0;
    end else begin
      clk_sync  <= {clk_sync[1:0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};

      if (!clk_sync[1])
        idle_cnt <= '0;
      else if (idle_cnt != CW'(TIMEOUT_CYC))
        idle_cnt <= idle_cnt + 1'b1;

      if (timeout) begin
        bit_cnt <= '0;
      end else if (fall) begin
        shift   <= {data_sync[1], shift[9:1]};
        bit_cnt <= last_bit ? 4'd0 : bit_cnt + 4'd1;
      end
    end
  end

endmodule

// File: rtl/ps2_mouse_regs.sv
// PS/2 mouse packet assembler with clamped cursor integration and a status/X/Y read port.
// Parity checking is enabled in ps2_rx_byte by defining PS2_MOUSE_RX_PARITY_CHECK_EN.
module ps2_mouse_regs
  import ps2_pkg::*;
#(
  parameter int X_MAX       = 255,
  parameter int Y_MAX       = 239,
  parameter int TIMEOUT_CYC = 5000
) (
  input  logic              clk,
  input  logic              rst,
  ps2_mouse_regs_if.slave   bus
);

  logic       byte_valid, frame_err, timeout;
  logic [7:0] byte_data;

  ps2_rx_byte #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_rx (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk    (bus.ps2_clk),
    .ps2_data   (bus.ps2_data),
    .byte_valid (byte_valid),
    .frame_err  (frame_err),
    .timeout    (timeout),
    .byte_data  (byte_data)
  );

  pkt_state_e state, state_next;
  logic [7:0] byte0_q, byte1_q, status_q, x_q, y_q;
  logic       dav_q;
  logic       load0, load1, commit;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_next = state;
    load0      = 1'b0;
    load1      = 1'b0;
    commit     = 1'b0;
    if (frame_err || timeout) begin
      state_next = BYTE0;
    end else if (byte_valid) begin
      unique case (state)
        BYTE0: if (byte_data[ALWAYS1]) begin
                 load0      = 1'b1;
                 state_next = BYTE1;
               end
        BYTE1: begin
                 load1      = 1'b1;
                 state_next = BYTE2;
               end
        BYTE2: begin
                 commit     = 1'b1;
                 state_next = BYTE0;
               end
        default: state_next = BYTE0;
      endcase
    end
  end

  // Byte 2 is still on byte_data during the commit cycle, so dY comes straight from it.
  logic signed [9:0] dx, dy, x_sum, y_diff;
  logic        [7:0] x_next, y_next;

  always_comb begin
    dx     = byte0_q[XOVF] ? 10'sd0
                           : $signed({byte0_q[XSIGN], byte0_q[XSIGN], byte1_q});
    dy     = byte0_q[YOVF] ? 10'sd0
                           : $signed({byte0_q[YSIGN], byte0_q[YSIGN], byte_data});
    x_sum  = $signed({2'b00, x_q}) + dx;
    y_diff = $signed({2'b00, y_q}) - dy;   // PS/2 +Y is up, screen +Y is down
    x_next = clamp_coord(x_sum, 8'(X_MAX));
    y_next = clamp_coord(y_diff, 8'(Y_MAX));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= BYTE0;
      byte0_q  <= '0;
      byte1_q  <= '0;
      status_q <= '0;
      x_q      <= '0;
      y_q      <= '0;
      dav_q    <= 1'b0;
    end else begin
      state <= state_next;
      dav_q <= commit;
      if (load0) byte0_q <= byte_data;
      if (load1) byte1_q <= byte_data;
      if (commit) begin
        status_q <= byte0_q;
        x_q      <= x_next;
        y_q      <= y_next;
      end
    end
  end

  always_comb begin
    bus.data = 8'h00;
    unique case (bus.addr)
      ADDR_STATUS: bus.data = status_q;
      ADDR_X:      bus.data = x_q;
      ADDR_Y:      bus.data = y_q;
      default:     bus.data = 8'h00;
    endcase
  end

  assign bus.dav = dav_q;

endmodule

// File: tb/tb_ps2_mouse_regs.sv
// Self-checking bench for ps2_mouse_regs: directed packets plus randomized traffic
// against a packet-level reference model.
module tb_ps2_mouse_regs;
  import ps2_pkg::*;

  localparam int X_MAX       = 255;
  localparam int Y_MAX       = 239;
  localparam int TIMEOUT_CYC = 200;
  localparam int HALF        = 20;   // clk cycles per PS/2 clock half period

`ifdef PS2_MOUSE_RX_PARITY_CHECK_EN
  localparam bit PAR_CHECK = 1'b1;
`else
  localparam bit PAR_CHECK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ps2_mouse_regs_if bus();

  ps2_mouse_regs #(
    .X_MAX       (X_MAX),
    .Y_MAX       (Y_MAX),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // dav monitor: counts pulses and flags back-to-back strobes.
  int   dav_cnt  = 0;
  logic dav_prev = 1'b0;
  always @(negedge clk) begin
    if (bus.dav === 1'b1) begin
      dav_cnt++;
      check("dav_single_cycle", {31'd0, dav_prev}, 32'd0);
    end
    dav_prev = bus.dav;
  end

  // Reference model: packet-level integration with plain integer arithmetic.
  int         m_x, m_y, m_idx, m_dav;
  logic [7:0] m_status, m_b0, m_b1;

  function automatic int clampi(input int v, input int hi);
    return (v < 0) ? 0 : (v > hi) ? hi : v;
  endfunction

  function automatic void model_reset();
    m_x = 0; m_y = 0; m_idx = 0; m_status = 8'h00;
  endfunction

  function automatic void model_frame(input logic [7:0] b, input bit ok);
    int dx, dy;
    if (!ok) begin
      m_idx = 0;
      return;
    end
    case (m_idx)
      0: if (b[3]) begin m_b0 = b; m_idx = 1; end
      1: begin m_b1 = b; m_idx = 2; end
      default: begin
        dx = m_b0[6] ? 0 : (m_b0[4] ? int'(m_b1) - 256 : int'(m_b1));
        dy = m_b0[7] ? 0 : (m_b0[5] ? int'(b) - 256 : int'(b));
        m_x      = clampi(m_x + dx, X_MAX);
        m_y      = clampi(m_y - dy, Y_MAX);
        m_status = m_b0;
        m_idx    = 0;
        m_dav++;
      end
    endcase
  endfunction

  task automatic send_frame(input logic [7:0] b, input bit bad_par = 0,
                            input bit bad_start = 0, input bit bad_stop = 0,
                            input int nbits = 11);
    logic [10:0] fr;
    fr[0]   = bad_start;
    fr[8:1] = b;
    fr[9]   = ~(^b) ^ bad_par;
    fr[10]  = ~bad_stop;
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      bus.ps2_data = fr[i];
      repeat (HALF) @(negedge clk);
      bus.ps2_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      bus.ps2_clk = 1'b1;
    end
    repeat (HALF) @(negedge clk);
    bus.ps2_data = 1'b1;
    if (nbits == 11)
      model_frame(b, !bad_start && !bad_stop && !(PAR_CHECK && bad_par));
  endtask

  task automatic read_reg(input logic [1:0] a, output logic [7:0] v);
    @(negedge clk);
    bus.addr = a;
    #1;
    v = bus.data;
  endtask

  task automatic check_model(input string tag);
    logic [7:0] v;
    read_reg(ADDR_STATUS, v); check({tag, "_status"}, v, m_status);
    read_reg(ADDR_X, v);      check({tag, "_x"}, v, m_x);
    read_reg(ADDR_Y, v);      check({tag, "_y"}, v, m_y);
  endtask

  task automatic check_const(input string tag, input int st, input int x, input int y);
    logic [7:0] v;
    read_reg(ADDR_STATUS, v); check({tag, "_status_k"}, v, st);
    read_reg(ADDR_X, v);      check({tag, "_x_k"}, v, x);
    read_reg(ADDR_Y, v);      check({tag, "_y_k"}, v, y);
  endtask

  // Send frames already issued, then let dav land and compare the pulse count.
  task automatic settle_dav(input string tag, input int dav0, input int mdav0);
    repeat (10) @(negedge clk);
    check({tag, "_dav"}, dav_cnt - dav0, m_dav - mdav0);
  endtask

  task automatic send_packet(input string tag, input logic [7:0] b0, b1, b2);
    int d0, md0;
    d0 = dav_cnt; md0 = m_dav;
    send_frame(b0);
    send_frame(b1);
    send_frame(b2);
    settle_dav(tag, d0, md0);
    check_model(tag);
  endtask

  initial begin
    logic [7:0] v;
    int d0, md0;
    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    bus.addr     = 2'd0;
    m_dav        = 0;
    model_reset();

    repeat (4) @(negedge clk);
    check("rst_dav", {31'd0, bus.dav}, 32'd0);
    for (int a = 0; a < 4; a++) begin
      read_reg(2'(a), v);
      check($sformatf("rst_addr%0d", a), v, 8'h00);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Move to Y=10, then the basic left-button packet.
    send_packet("to_y10", 8'h28, 8'h00, 8'hF6);
    check_const("to_y10", 8'h28, 0, 10);
    send_packet("basic", 8'h09, 8'h05, 8'h03);
    check_const("basic", 8'h09, 5, 7);

    // Move to X=3, Y=230, then drive both axes into their clamps.
    send_packet("to_x3", 8'h38, 8'hFE, 8'h21);
    check_const("to_x3", 8'h38, 3, 230);
    send_packet("clamp", 8'h38, 8'hF6, 8'h02);
    check_const("clamp", 8'h38, 0, Y_MAX);
    read_reg(2'd3, v);
    check("reserved_addr", v, 8'h00);

    // Misaligned first byte is discarded.
    d0 = dav_cnt; md0 = m_dav;
    send_frame(8'h00);
    send_packet("align", 8'h08, 8'h01, 8'h01);
    check("align_total_dav", dav_cnt - d0, 1);
    check_const("align", 8'h08, 1, 238);

    // Parity error on byte 1.
    d0 = dav_cnt; md0 = m_dav;
    send_frame(8'h08);
    send_frame(8'h05, 1'b1);
    send_frame(8'h03);
    settle_dav("parity", d0, md0);
    check_model("parity");
`ifdef PS2_MOUSE_RX_PARITY_CHECK_EN
    check("parity_dav_k", dav_cnt - d0, 0);
    check_const("parity", 8'h08, 1, 238);
`else
    check("parity_dav_k", dav_cnt - d0, 1);
    check_const("parity", 8'h08, 6, 235);
`endif

    // Bad stop then bad start bit, followed by a clean packet.
    d0 = dav_cnt; md0 = m_dav;
    send_frame(8'h08, 1'b0, 1'b0, 1'b1);
    send_frame(8'h01);
    send_frame(8'h09, 1'b0, 1'b1, 1'b0);
    send_packet("framing", 8'h09, 8'h01, 8'h00);
    check("framing_total_dav", dav_cnt - d0, 1);

    // Timeout after 5 bits of byte 1, then a fresh packet.
    d0 = dav_cnt; md0 = m_dav;
    send_frame(8'h08);
    send_frame(8'h40, 1'b0, 1'b0, 1'b0, 5);
    repeat (TIMEOUT_CYC + 20) @(negedge clk);
    m_idx = 0;
    send_packet("timeout", 8'h09, 8'h02, 8'h01);
    check("timeout_total_dav", dav_cnt - d0, 1);

    // Reset in the middle of a packet.
    d0 = dav_cnt;
    send_frame(8'h08);
    send_frame(8'h10);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    check("midrst_dav", {31'd0, bus.dav}, 32'd0);
    check_const("midrst", 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("midrst_no_dav", dav_cnt - d0, 0);

    // Randomized traffic.
    for (int p = 0; p < 20; p++) begin
      logic [7:0] b0, b1, b2;
      b0 = 8'($urandom);
      if ($urandom_range(0, 3) != 0) b0[3] = 1'b1;
      b1 = 8'($urandom);
      b2 = 8'($urandom);
      d0 = dav_cnt; md0 = m_dav;
      send_frame(b0);
      send_frame(b1, $urandom_range(0, 7) == 0);
      send_frame(b2);
      settle_dav($sformatf("rnd%0d", p), d0, md0);
      check_model($sformatf("rnd%0d", p));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
